// File: rtl/uart_config_fsm_pkg.sv
// Shared types and constants for the UART runtime-configuration front end.
// A configuration packet is {dont_care[3:0], option[1:0], id[1:0]}.
package uart_config_fsm_pkg;

   localparam logic [7:0] SYN = 8'h16;
   localparam int SYN_NUMBER = 3;
   localparam int unsigned CONFIG_TIMEOUT_DEFAULT = 10_000_000;

   typedef enum logic [1:0] {
      END_CONFIGURATION_ID = 2'd0,
      DATA_WIDTH_ID        = 2'd1,
      PARITY_MODE_ID       = 2'd2,
      STOP_BITS_ID         = 2'd3
   } packet_id_e;

   typedef enum logic [1:0] {DW_5BIT, DW_6BIT, DW_7BIT, DW_8BIT} data_width_e;
   typedef enum logic [1:0] {DISABLED1, PM_EVEN, PM_ODD, DISABLED2} parity_mode_e;
   typedef enum logic [1:0] {SB_1BIT, SB_2BIT, RESERVED1, RESERVED2} stop_bits_e;

   typedef struct packed {
      data_width_e  data_width;
      parity_mode_e parity_mode;
      stop_bits_e   stop_bits;
   } uart_config_s;

   localparam uart_config_s STD_CONFIGURATION = '{data_width: DW_8BIT,
                                                  parity_mode: DISABLED1,
                                                  stop_bits: SB_1BIT};

   typedef struct packed {
      logic [3:0] dont_care;
      logic [1:0] option;
      packet_id_e id;
   } cfg_packet_s;

   typedef union packed {
      logic [7:0]  raw;
      cfg_packet_s cfg_packet;
   } data_packet_u;

   typedef enum logic [1:0] {MAIN, CONFIG, SEND_ACK} config_fsm_state_e;

   function automatic packet_id_e pkt_id(input logic [7:0] b);
      data_packet_u p;
      p.raw = b;
      return p.cfg_packet.id;
   endfunction

   function automatic logic [1:0] pkt_option(input logic [7:0] b);
      data_packet_u p;
      p.raw = b;
      return p.cfg_packet.option;
   endfunction

   // Reserved stop-bit encodings are the only packets rejected.
   function automatic logic pkt_legal(input logic [7:0] b);
      return !((pkt_id(b) == STOP_BITS_ID) &&
               ((pkt_option(b) == 2'(RESERVED1)) || (pkt_option(b) == 2'(RESERVED2))));
   endfunction

endpackage

// File: rtl/uart_config_fsm_syn_detector.sv
// Counts consecutive SYN bytes while enabled; o_match flags the byte that completes the run.
module uart_syn_detector
   import uart_config_fsm_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       i_en,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_match
);

   localparam int CW = $clog2(SYN_NUMBER + 1);

   logic [CW-1:0] r_syn_cnt;
   logic          w_is_syn;

   assign w_is_syn = i_en && i_valid && (i_data == SYN);
   assign o_match  = w_is_syn && (r_syn_cnt == CW'(SYN_NUMBER - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_syn_cnt <= '0;
      end else if (i_en && i_valid) begin
         if (o_match || !w_is_syn) r_syn_cnt <= '0;
         else                      r_syn_cnt <= r_syn_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_config_fsm.sv
// Runtime-configuration front end: forwards RX bytes in MAIN, decodes and echoes config
// packets after a SYN run, and commits the new framing only once the END ack has gone out.
//
// state    | meaning
// MAIN     | normal traffic, bytes forwarded, SYN run watched
// CONFIG   | decoding packets into the shadow config, timeout running
// SEND_ACK | echo byte held on tx until tx_done_i, timeout frozen
module uart_config_fsm
   import uart_config_fsm_pkg::*;
#(
   parameter int unsigned CONFIG_TIMEOUT = CONFIG_TIMEOUT_DEFAULT
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic [7:0] rx_fwd_data_o,
   output logic       rx_fwd_valid_o,
   output logic [7:0] tx_data_o,
   output logic       tx_req_o,
   input  logic       tx_done_i,
   output logic [5:0] config_o,
   output logic       config_active_o,
   output logic       config_req_o,
   output logic       config_fail_o
);

   localparam int TW = $clog2(CONFIG_TIMEOUT);

   config_fsm_state_e r_state, w_state_nxt;
   uart_config_s      r_config, w_config_nxt, r_shadow, w_shadow_nxt;
   logic [TW-1:0]     r_tmo_cnt, w_tmo_cnt_nxt;
   logic [7:0]        r_fwd_data, w_fwd_data_nxt, r_tx_data, w_tx_data_nxt;
   logic              r_fwd_valid, w_fwd_valid_nxt, r_tx_req, w_tx_req_nxt;
   logic              r_cfg_req, w_cfg_req_nxt, r_cfg_fail, w_cfg_fail_nxt;
   logic              r_is_end, w_is_end_nxt, r_active;
   logic              w_syn_match, w_pkt_legal, w_tmo_hit;
   packet_id_e        w_pkt_id;
   logic [1:0]        w_pkt_opt;

   uart_syn_detector u_syn_detector (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .i_en    (r_state == MAIN),
      .i_valid (rx_valid_i),
      .i_data  (rx_data_i),
      .o_match (w_syn_match)
   );

   assign w_pkt_id    = pkt_id(rx_data_i);
   assign w_pkt_opt   = pkt_option(rx_data_i);
   assign w_pkt_legal = pkt_legal(rx_data_i);
   // Abort on the clock where the idle count would reach CONFIG_TIMEOUT-1.
   assign w_tmo_hit   = (r_tmo_cnt == TW'(CONFIG_TIMEOUT - 2));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= MAIN;
         r_config    <= STD_CONFIGURATION;
         r_shadow    <= STD_CONFIGURATION;
         r_tmo_cnt   <= '0;
         r_fwd_data  <= '0;
         r_fwd_valid <= 1'b0;
         r_tx_data   <= '0;
         r_tx_req    <= 1'b0;
         r_cfg_req   <= 1'b0;
         r_cfg_fail  <= 1'b0;
         r_is_end    <= 1'b0;
         r_active    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_config    <= w_config_nxt;
         r_shadow    <= w_shadow_nxt;
         r_tmo_cnt   <= w_tmo_cnt_nxt;
         r_fwd_data  <= w_fwd_data_nxt;
         r_fwd_valid <= w_fwd_valid_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_tx_req    <= w_tx_req_nxt;
         r_cfg_req   <= w_cfg_req_nxt;
         r_cfg_fail  <= w_cfg_fail_nxt;
         r_is_end    <= w_is_end_nxt;
         r_active    <= (w_state_nxt != MAIN);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MAIN:     if (w_syn_match) w_state_nxt = CONFIG;
         CONFIG: begin
            if (rx_valid_i) begin
               if (w_pkt_legal) w_state_nxt = SEND_ACK;
            end else if (w_tmo_hit) begin
               w_state_nxt = MAIN;
            end
         end
         SEND_ACK: if (tx_done_i) w_state_nxt = r_is_end ? MAIN : CONFIG;
         default:  w_state_nxt = MAIN;
      endcase
   end

   always_comb begin
      w_fwd_valid_nxt = 1'b0;
      w_fwd_data_nxt  = r_fwd_data;
      w_tx_req_nxt    = r_tx_req;
      w_tx_data_nxt   = r_tx_data;
      w_cfg_req_nxt   = 1'b0;
      w_cfg_fail_nxt  = 1'b0;
      w_config_nxt    = r_config;
      w_shadow_nxt    = r_shadow;
      w_is_end_nxt    = r_is_end;
      w_tmo_cnt_nxt   = r_tmo_cnt;
      case (r_state)
         MAIN: begin
            if (rx_valid_i) begin
               w_fwd_valid_nxt = 1'b1;
               w_fwd_data_nxt  = rx_data_i;
            end
            if (w_syn_match) begin
               w_cfg_req_nxt = 1'b1;
               w_shadow_nxt  = r_config;
               w_tmo_cnt_nxt = '0;
            end
         end
         CONFIG: begin
            if (rx_valid_i) begin
               w_tmo_cnt_nxt = '0;
               if (w_pkt_legal) begin
                  case (w_pkt_id)
                     DATA_WIDTH_ID:        w_shadow_nxt.data_width  = data_width_e'(w_pkt_opt);
                     PARITY_MODE_ID:       w_shadow_nxt.parity_mode = parity_mode_e'(w_pkt_opt);
                     STOP_BITS_ID:         w_shadow_nxt.stop_bits   = stop_bits_e'(w_pkt_opt);
                     END_CONFIGURATION_ID: w_shadow_nxt = r_shadow;
                     default:              w_shadow_nxt = r_shadow;
                  endcase
                  w_tx_data_nxt = rx_data_i;
                  w_tx_req_nxt  = 1'b1;
                  w_is_end_nxt  = (w_pkt_id == END_CONFIGURATION_ID);
               end else begin
                  w_cfg_fail_nxt = 1'b1;
               end
            end else if (w_tmo_hit) begin
               w_cfg_fail_nxt = 1'b1;
               w_tmo_cnt_nxt  = '0;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
            end
         end
         SEND_ACK: begin
            if (rx_valid_i) w_cfg_fail_nxt = 1'b1;
            if (tx_done_i) begin
               w_tx_req_nxt = 1'b0;
               // The ack left in the old framing; only now switch to the new one.
               if (r_is_end) w_config_nxt  = r_shadow;
               else          w_tmo_cnt_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   assign rx_fwd_data_o   = r_fwd_data;
   assign rx_fwd_valid_o  = r_fwd_valid;
   assign tx_data_o       = r_tx_data;
   assign tx_req_o        = r_tx_req;
   assign config_o        = r_config;
   assign config_active_o = r_active;
   assign config_req_o    = r_cfg_req;
   assign config_fail_o   = r_cfg_fail;

endmodule

// File: tb/tb_uart_config_fsm.sv
// Bench for uart_config_fsm: directed scenarios plus randomized traffic, every cycle compared
// against a behavioural model of the configuration protocol.
module tb_uart_config_fsm;

   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] rx_fwd_data, tx_data;
   logic       rx_fwd_valid, tx_req, cfg_active, cfg_req, cfg_fail;
   logic [5:0] cfg;

   always #5 clk = ~clk;

   uart_config_fsm #(.CONFIG_TIMEOUT(TMO)) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .rx_data_i       (rx_data),
      .rx_valid_i      (rx_valid),
      .rx_fwd_data_o   (rx_fwd_data),
      .rx_fwd_valid_o  (rx_fwd_valid),
      .tx_data_o       (tx_data),
      .tx_req_o        (tx_req),
      .tx_done_i       (tx_done),
      .config_o        (cfg),
      .config_active_o (cfg_active),
      .config_req_o    (cfg_req),
      .config_fail_o   (cfg_fail)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] cfg_word(input int dw, input int pm, input int sb);
      return {2'(dw), 2'(pm), 2'(sb)};
   endfunction

   // Behavioural model: mode 0 = normal traffic, 1 = configuring, 2 = waiting for ack.
   int         m_mode, m_run, m_idle, m_dw, m_pm, m_sb, s_dw, s_pm, s_sb;
   bit         m_end;
   logic       e_fwd_v, e_req, e_fail, e_tx_req;
   logic [7:0] e_fwd_d, e_tx_d;

   initial begin
      int id, opt;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_mode = 0; m_run = 0; m_idle = 0; m_end = 0;
            m_dw = 3; m_pm = 0; m_sb = 0; s_dw = 3; s_pm = 0; s_sb = 0;
            e_fwd_v = 0; e_req = 0; e_fail = 0; e_tx_req = 0; e_fwd_d = 0; e_tx_d = 0;
         end else begin
            e_fwd_v = 0; e_req = 0; e_fail = 0;
            case (m_mode)
               0: if (rx_valid) begin
                     e_fwd_v = 1; e_fwd_d = rx_data;
                     m_run = (rx_data == 8'h16) ? m_run + 1 : 0;
                     if (m_run == 3) begin
                        m_run = 0; e_req = 1; m_mode = 1; m_idle = 0;
                        s_dw = m_dw; s_pm = m_pm; s_sb = m_sb;
                     end
                  end
               1: if (rx_valid) begin
                     m_idle = 0;
                     id  = int'(rx_data[1:0]);
                     opt = int'(rx_data[3:2]);
                     if (id == 3 && opt >= 2) e_fail = 1;
                     else begin
                        if (id == 1) s_dw = opt;
                        if (id == 2) s_pm = opt;
                        if (id == 3) s_sb = opt;
                        e_tx_d = rx_data; e_tx_req = 1; m_end = (id == 0); m_mode = 2;
                     end
                  end else begin
                     m_idle++;
                     if (m_idle == TMO - 1) begin e_fail = 1; m_mode = 0; end
                  end
               default: begin
                  if (rx_valid) e_fail = 1;
                  if (tx_done) begin
                     e_tx_req = 0;
                     if (m_end) begin
                        m_dw = s_dw; m_pm = s_pm; m_sb = s_sb; m_mode = 0;
                     end else begin
                        m_mode = 1; m_idle = 0;
                     end
                  end
               end
            endcase
         end
      end
   end

   // Per-cycle comparison plus event bookkeeping for the directed checks.
   int         n_fwd = 0, n_req = 0, n_failp = 0, req_fwd_idx = 0;
   logic       req_with_fwd = 1'b0, prev_tx_req = 1'b0;
   logic [7:0] echo_q[$];

   initial forever begin
      @(negedge clk);
      chk("config_o",        32'(cfg),          32'(cfg_word(m_dw, m_pm, m_sb)));
      chk("config_active_o", 32'(cfg_active),   32'(m_mode != 0));
      chk("tx_req_o",        32'(tx_req),       32'(e_tx_req));
      chk("config_req_o",    32'(cfg_req),      32'(e_req));
      chk("config_fail_o",   32'(cfg_fail),     32'(e_fail));
      chk("rx_fwd_valid_o",  32'(rx_fwd_valid), 32'(e_fwd_v));
      if (e_fwd_v)  chk("rx_fwd_data_o", 32'(rx_fwd_data), 32'(e_fwd_d));
      if (e_tx_req) chk("tx_data_o",     32'(tx_data),     32'(e_tx_d));
      if (rx_fwd_valid) n_fwd++;
      if (cfg_req) begin n_req++; req_fwd_idx = n_fwd; req_with_fwd = rx_fwd_valid; end
      if (cfg_fail) n_failp++;
      if (tx_req && !prev_tx_req) echo_q.push_back(tx_data);
      prev_tx_req = tx_req;
   end

   // Transmitter stand-in: answers each request after 0..3 extra cycles.
   bit auto_ack = 1'b1;
   int ack_dly  = 0;
   initial forever begin
      @(posedge clk); #2;
      tx_done = 1'b0;
      if (auto_ack && tx_req) begin
         if (ack_dly == 0) begin tx_done = 1'b1; ack_dly = $urandom_range(0, 3); end
         else ack_dly--;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #2;
      rx_valid = 1'b1; rx_data = b;
      @(posedge clk); #2;
      rx_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 40 && tx_req; i++) begin @(posedge clk); #2; end
      chk("ack_wait_bound", 32'(tx_req), 32'd0);
   endtask

   task automatic wait_main();
      for (int i = 0; i < 40 && cfg_active; i++) begin @(posedge clk); #2; end
      chk("main_wait_bound", 32'(cfg_active), 32'd0);
   endtask

   task automatic enter_config();
      repeat (3) send_byte(8'h16);
      chk("enter_config", 32'(cfg_active), 32'd1);
   endtask

   initial begin
      automatic logic [7:0] seq2[6] = '{8'h16, 8'h16, 8'h41, 8'h16, 8'h16, 8'h16};
      automatic logic [7:0] seq3[4] = '{8'h01, 8'h06, 8'h07, 8'h00};
      int base_fwd, base_req, base_fail, base_echo, k;

      repeat (3) @(posedge clk); #2;
      chk("reset_config",  32'(cfg),        32'h30);
      chk("reset_active",  32'(cfg_active), 32'd0);
      chk("reset_tx_req",  32'(tx_req),     32'd0);
      rst_n = 1'b1;
      settle();

      base_fwd = n_fwd; base_req = n_req;
      foreach (seq2[i]) send_byte(seq2[i]);
      settle();
      chk("syn_fwd_count",  32'(n_fwd - base_fwd),       32'd6);
      chk("syn_req_count",  32'(n_req - base_req),       32'd1);
      chk("syn_req_on_6th", 32'(req_fwd_idx - base_fwd), 32'd6);
      chk("syn_req_fwd",    32'(req_with_fwd),           32'd1);

      base_echo = echo_q.size();
      for (int i = 0; i < 3; i++) begin send_byte(seq3[i]); wait_ack(); end
      chk("cfg_before_end", 32'(cfg), 32'h30);
      send_byte(seq3[3]);
      chk("cfg_during_end_ack", 32'(cfg), 32'h30);
      wait_main();
      settle();
      chk("cfg_after_end", 32'(cfg), 32'h05);
      chk("echo_count", 32'(echo_q.size() - base_echo), 32'd4);
      if (echo_q.size() - base_echo == 4)
         for (int i = 0; i < 4; i++) chk("echo_byte", 32'(echo_q[base_echo + i]), 32'(seq3[i]));

      enter_config();
      base_fail = n_failp;
      send_byte(8'h0B);
      settle();
      chk("reserved_fail",   32'(n_failp - base_fail), 32'd1);
      chk("reserved_no_req", 32'(tx_req),              32'd0);
      chk("reserved_stay",   32'(cfg_active),          32'd1);
      send_byte(8'h00);
      wait_ack();
      wait_main();
      chk("reserved_shadow_kept", 32'(cfg), 32'h05);

      enter_config();
      k = 0;
      while (k < 40) begin
         @(posedge clk); #2;
         k++;
         if (cfg_fail) break;
      end
      chk("timeout_cycles", 32'(k),          32'd15);
      settle();
      chk("timeout_main",   32'(cfg_active), 32'd0);
      chk("timeout_config", 32'(cfg),        32'h05);

      auto_ack = 1'b0;
      enter_config();
      send_byte(8'h01);
      base_fwd = n_fwd; base_fail = n_failp;
      send_byte(8'h41);
      settle();
      chk("ack_drop_fail",  32'(n_failp - base_fail), 32'd1);
      chk("ack_drop_nofwd", 32'(n_fwd - base_fwd),    32'd0);
      chk("ack_held",       32'(tx_req),              32'd1);
      auto_ack = 1'b1;
      wait_ack();
      chk("ack_back_config", 32'(cfg_active), 32'd1);
      send_byte(8'h00);
      wait_ack();
      wait_main();

      enter_config();
      send_byte(8'h0D);
      wait_ack();
      rst_n = 1'b0;
      #1;
      chk("midcfg_reset_config", 32'(cfg),        32'h30);
      chk("midcfg_reset_active", 32'(cfg_active), 32'd0);
      repeat (2) @(posedge clk); #2;
      rst_n = 1'b1;

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         if (c == 1500) rst_n = 1'b0;
         if (c == 1503) rst_n = 1'b1;
         if ((c % 200) < 20) rx_valid = 1'b0;
         else                rx_valid = ($urandom_range(0, 9) < 6);
         rx_data = ($urandom_range(0, 9) < 4) ? 8'h16 : 8'($urandom);
      end
      rx_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
